// File: rtl/fwd_ctrl_unit.sv
// Forwarding and load-use hazard controller.
// Tracks destination tags for the EX, MEM, WB and RET stages in a shadow
// pipeline. From those tags it drives the EX operand A/B forwarding mux
// selects and raises the load-use stall. It also keeps a saturating count
// of stall cycles.
module fwd_ctrl_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             i_CLK,
  input  logic             i_RST_N,
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_uses_rs,
  input  logic             i_id_uses_rt,
  input  logic [REG_W-1:0] i_id_rd,
  input  logic             i_id_regwrite,
  input  logic             i_id_memread,
  input  logic             i_flush,
  input  logic             i_freeze,
  output logic [1:0]       o_fwd_a_sel,
  output logic [1:0]       o_fwd_b_sel,
  output logic             o_stall,
  output logic [CNT_W-1:0] o_stall_cnt
);

  // Stage tags: p0 = EX, p1 = MEM, p2 = WB, p3 = RET.
  logic             vld_p0, vld_p1, vld_p2, vld_p3;
  logic [REG_W-1:0] rs_p0, rt_p0;
  logic [REG_W-1:0] rd_p0, rd_p1, rd_p2, rd_p3;
  logic             rw_p0, rw_p1, rw_p2, rw_p3;
  logic             mr_p0;
  logic             ex_load_ok;

  // A stage produces register r when it will write a non-zero rd equal to r.
  function automatic logic produces(input logic v, input logic rw,
                                    input logic [REG_W-1:0] rd,
                                    input logic [REG_W-1:0] r);
    return v & rw & (rd == r) & (rd != '0);
  endfunction

  // The youngest producer wins: MEM, then WB, then RET, then the register file.
  function automatic logic [1:0] pick_sel(input logic hit_mem, input logic hit_wb,
                                          input logic hit_ret);
    if (hit_mem)     return 2'b01;
    else if (hit_wb) return 2'b10;
    else if (hit_ret) return 2'b11;
    else             return 2'b00;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // A load in EX with a non-zero destination can only stall a dependent ID instruction.
  assign ex_load_ok = vld_p0 & mr_p0 & (rd_p0 != '0);

  // Load-use stall: combinational so the PC and IF/ID enables see it in the same cycle.
  always_comb begin
    o_stall = i_id_valid & ~i_flush & ex_load_ok &
              ((i_id_uses_rs & (i_id_rs == rd_p0)) |
               (i_id_uses_rt & (i_id_rt == rd_p0)));
  end

  // Operand selects are derived only from registered stage tags.
  always_comb begin
    o_fwd_a_sel = 2'b00;
    o_fwd_b_sel = 2'b00;
    if (vld_p0) begin
      o_fwd_a_sel = pick_sel(produces(vld_p1, rw_p1, rd_p1, rs_p0),
                             produces(vld_p2, rw_p2, rd_p2, rs_p0),
                             produces(vld_p3, rw_p3, rd_p3, rs_p0));
      o_fwd_b_sel = pick_sel(produces(vld_p1, rw_p1, rd_p1, rt_p0),
                             produces(vld_p2, rw_p2, rd_p2, rt_p0),
                             produces(vld_p3, rw_p3, rd_p3, rt_p0));
    end
  end

  // Control state: stage valids and stall counter, both held while frozen.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      vld_p3      <= 1'b0;
      o_stall_cnt <= '0;
    end else if (!i_freeze) begin
      // ID -> EX: flush, stall or an empty ID slot becomes a bubble.
      vld_p0 <= i_id_valid & ~i_flush & ~o_stall;
      // EX -> MEM -> WB -> RET
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      if (o_stall) o_stall_cnt <= sat_inc(o_stall_cnt);
    end
  end

  // Tag payload: loaded regardless of validity, since valid alone qualifies it.
  always_ff @(posedge i_CLK) begin
    if (!i_freeze) begin
      // ID -> EX
      rs_p0 <= i_id_rs;
      rt_p0 <= i_id_rt;
      rd_p0 <= i_id_rd;
      rw_p0 <= i_id_regwrite;
      mr_p0 <= i_id_memread;
      // EX -> MEM
      rd_p1 <= rd_p0;
      rw_p1 <= rw_p0;
      // MEM -> WB
      rd_p2 <= rd_p1;
      rw_p2 <= rw_p1;
      // WB -> RET
      rd_p3 <= rd_p2;
      rw_p3 <= rw_p2;
    end
  end

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// Directed bench for fwd_ctrl_unit. A second instance with a 2-bit counter
// exercises the saturation behaviour within a short run.
module tb_fwd_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, uses_rs, uses_rt, regwrite, memread, flush, freeze;
  logic [4:0]  rs, rt, rd;
  logic [1:0]  a_sel, b_sel, s_a_sel, s_b_sel;
  logic        stall, s_stall;
  logic [15:0] cnt;
  logic [1:0]  s_cnt;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  fwd_ctrl_unit #(.REG_W(5), .CNT_W(16)) u_dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_id_valid(id_valid),
    .i_id_rs(rs), .i_id_rt(rt), .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt),
    .i_id_rd(rd), .i_id_regwrite(regwrite), .i_id_memread(memread),
    .i_flush(flush), .i_freeze(freeze),
    .o_fwd_a_sel(a_sel), .o_fwd_b_sel(b_sel), .o_stall(stall), .o_stall_cnt(cnt)
  );

  fwd_ctrl_unit #(.REG_W(5), .CNT_W(2)) u_sat (
    .i_CLK(clk), .i_RST_N(rst_n), .i_id_valid(id_valid),
    .i_id_rs(rs), .i_id_rt(rt), .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt),
    .i_id_rd(rd), .i_id_regwrite(regwrite), .i_id_memread(memread),
    .i_flush(flush), .i_freeze(freeze),
    .o_fwd_a_sel(s_a_sel), .o_fwd_b_sel(s_b_sel), .o_stall(s_stall), .o_stall_cnt(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present an ID instruction: valid, rs, rt, uses_rs, uses_rt, rd, regwrite, memread.
  task automatic id(input logic v, input logic [4:0] s, input logic [4:0] t,
                    input logic us, input logic ut, input logic [4:0] d,
                    input logic w, input logic m);
    id_valid = v; rs = s; rt = t; uses_rs = us; uses_rt = ut;
    rd = d; regwrite = w; memread = m;
    #1;
  endtask

  task automatic nop();
    id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    for (int i = 0; i < 5; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; freeze = 1'b0;
    nop();
    #1;
    // Reset state before any clock edge
    chk("rst_a_sel", a_sel, 2'b00);
    chk("rst_b_sel", b_sel, 2'b00);
    chk("rst_stall", stall, 1'b0);
    chk("rst_cnt", cnt, 16'd0);
    tick();
    rst_n = 1'b1;
    drain();

    // Back-to-back ALU dependency on $3
    id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);  tick();         // add $3
    id(1, 5'd3, 5'd4, 1, 1, 5'd8, 1, 0);                  // sub rs=$3
    chk("alu_no_stall", stall, 1'b0);
    tick();
    id(1, 5'd9, 5'd3, 1, 1, 5'd10, 1, 0);                 // and rt=$3
    chk("alu_a_mem", a_sel, 2'b01);
    chk("alu_b_rf", b_sel, 2'b00);
    tick();
    id(1, 5'd3, 5'd11, 1, 1, 5'd12, 1, 0);                // third consumer
    chk("alu_b_wb", b_sel, 2'b10);
    chk("alu_a_rf", a_sel, 2'b00);
    tick();
    id(1, 5'd3, 5'd14, 1, 1, 5'd13, 1, 0);                // fourth consumer
    chk("alu_a_ret", a_sel, 2'b11);
    tick();
    nop();
    chk("alu_a_gone", a_sel, 2'b00);
    drain();

    // Load-use: lw $5 then add rs=$5
    id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);  tick();
    id(1, 5'd5, 5'd6, 1, 1, 5'd7, 1, 0);
    chk("lu_stall", stall, 1'b1);
    tick();                                               // IF/ID held: same add in ID
    chk("lu_stall_once", stall, 1'b0);
    chk("lu_cnt1", cnt, 16'd1);
    chk("lu_ex_bubble_a", a_sel, 2'b00);
    tick();
    nop();
    chk("lu_a_wb", a_sel, 2'b10);
    chk("lu_b_rf", b_sel, 2'b00);
    chk("lu_cnt_hold", cnt, 16'd1);
    drain();

    // $0 never forwards or stalls
    id(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 1);  tick();         // load to $0
    id(1, 5'd0, 5'd0, 1, 1, 5'd4, 1, 0);
    chk("z_no_stall", stall, 1'b0);
    tick();
    nop();
    chk("z_a_sel", a_sel, 2'b00);
    chk("z_b_sel", b_sel, 2'b00);
    drain();

    // Two writers of $7: MEM beats WB
    id(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 0);  tick();
    id(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 0);  tick();
    id(1, 5'd7, 5'd7, 1, 1, 5'd9, 1, 0);  tick();
    nop();
    chk("pri_a_mem", a_sel, 2'b01);
    chk("pri_b_mem", b_sel, 2'b01);
    drain();

    // Flush wins over stall; flushed add of $7 must not reach MEM
    id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);  tick();
    flush = 1'b1;
    id(1, 5'd5, 5'd6, 1, 1, 5'd7, 1, 0);
    chk("fl_no_stall", stall, 1'b0);
    tick();
    flush = 1'b0;
    chk("fl_cnt_same", cnt, 16'd1);
    id(1, 5'd7, 5'd12, 1, 1, 5'd8, 1, 0);  tick();
    nop();
    chk("fl_bubble_a", a_sel, 2'b00);
    drain();

    // Freeze during a load-use hazard
    id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);  tick();
    freeze = 1'b1;
    id(1, 5'd6, 5'd5, 1, 1, 5'd7, 1, 0);
    chk("fz_stall0", stall, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("fz_stall%0d", i), stall, 1'b1);
      chk($sformatf("fz_cnt%0d", i), cnt, 16'd1);
    end
    freeze = 1'b0;
    #1;
    tick();
    chk("fz_stall_drop", stall, 1'b0);
    chk("fz_cnt_inc", cnt, 16'd2);
    tick();
    nop();
    chk("fz_b_wb", b_sel, 2'b10);
    chk("fz_a_rf", a_sel, 2'b00);
    drain();

    // Async reset mid-cycle with live tags and an active stall
    id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);  tick();         // add $3
    id(1, 5'd3, 5'd0, 1, 0, 5'd9, 1, 1);  tick();         // lw $9 reads $3
    id(1, 5'd9, 5'd0, 1, 0, 5'd4, 1, 0);
    chk("pre_rst_a", a_sel, 2'b01);
    chk("pre_rst_stall", stall, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a", a_sel, 2'b00);
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_cnt", cnt, 16'd0);
    chk("mid_rst_scnt", s_cnt, 2'd0);
    tick();
    rst_n = 1'b1;
    // First edge after release loads EX from ID normally
    id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);  tick();
    id(1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 0);
    chk("rel_stall", stall, 1'b1);
    chk("rel_a_rf", a_sel, 2'b00);
    tick(); tick();
    drain();
    chk("rel_cnt", cnt, 16'd1);

    // Saturation: the 2-bit counter sticks at 3
    for (int k = 2; k <= 5; k++) begin
      id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);  tick();
      id(1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 0);  tick(); tick();
      nop();
      chk($sformatf("sat_cnt%0d", k), cnt, k);
      chk($sformatf("sat_scnt%0d", k), s_cnt, (k > 3) ? 3 : k);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Run-time bound so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
